// File: rtl/fifo_rr_write_arbiter_pkg.sv
// rtl/fifo_rr_write_arbiter_pkg.sv - shared types and constants for the FIFO write arbiter
// Purpose: arbiter FSM state type, default sizing, occupancy width helper.
// Ports: none (package).
package fifo_rr_write_arbiter_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } arb_state_t;

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_rr_write_arbiter_if.sv
// rtl/fifo_rr_write_arbiter_if.sv - producer/FIFO side bundle of the write arbiter
// Purpose: groups requester handshake, FIFO write port and observed FIFO read side.
// Ports: slave = arbiter view, master = producers/FIFO/consumer view.
interface fifo_rr_write_arbiter_if
    import fifo_rr_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int OCC_W = occ_width(FIFO_DEPTH);

    logic [NUM_REQ-1:0]            Req_In;
    logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_In;
    logic [NUM_REQ-1:0]            Ack_Out;
    logic [DATA_WIDTH-1:0]         Fifo_Data_Out;
    logic                          Fifo_Wr_En_Out;
    logic                          Fifo_Rd_En_In;
    logic                          Fifo_Empty_In;
    logic [OCC_W-1:0]              Occupancy_Out;
    logic                          Stall_Out;

    modport slave (
        input  Req_In, Req_Data_In, Fifo_Rd_En_In, Fifo_Empty_In,
        output Ack_Out, Fifo_Data_Out, Fifo_Wr_En_Out, Occupancy_Out, Stall_Out
    );

    modport master (
        output Req_In, Req_Data_In, Fifo_Rd_En_In, Fifo_Empty_In,
        input  Ack_Out, Fifo_Data_Out, Fifo_Wr_En_Out, Occupancy_Out, Stall_Out
    );

endinterface

// File: rtl/fifo_rr_write_arbiter_picker.sv
// rtl/fifo_rr_write_arbiter_picker.sv - combinational round-robin winner select
// Purpose: first eligible index at or after the pointer, wrapping to 0.
// Ports: i_elig (eligible mask), i_pointer (priority start),
//        o_valid (any eligible), o_winner (selected index).
module rr_priority_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_elig,
    input  logic [IDX_W-1:0]   i_pointer,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_winner
);

    int w_idx;

    // Scan offsets from far to near so the nearest eligible index is assigned last.
    always_comb begin
        w_idx    = 0;
        o_valid  = |i_elig;
        o_winner = i_pointer;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_idx = (int'(i_pointer) + off) % NUM_REQ;
            if (i_elig[w_idx]) begin
                o_winner = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// rtl/fifo_rr_write_arbiter.sv - round-robin shared write port for one FIFO with credit tracking
// Purpose: one FIFO write per clock, round-robin among requesters, own occupancy
//          count so the lagging FIFO full flag is never relied on.
// Ports: Clk_In (rising edge), Reset_In (sync, active-low),
//        bus (slave): Req_In/Req_Data_In/Ack_Out requester handshake,
//        Fifo_Data_Out/Fifo_Wr_En_Out to FIFO, Fifo_Rd_En_In/Fifo_Empty_In observed,
//        Occupancy_Out credited words, Stall_Out blocked by zero credit.
module fifo_rr_write_arbiter
    import fifo_rr_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   Clk_In,
    input  logic                   Reset_In,
    fifo_rr_write_arbiter_if.slave bus
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               OCC_W    = occ_width(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(FIFO_DEPTH);

    logic [NUM_REQ-1:0]    r_ack;
    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic [OCC_W-1:0]      r_occ;
    logic [IDX_W-1:0]      r_ptr;
    arb_state_t            r_state;

    logic [NUM_REQ-1:0]    w_elig;
    logic                  w_valid;
    logic [IDX_W-1:0]      w_winner;
    logic                  w_credit;
    logic                  w_grant;
    logic                  w_rd_acc;
    logic [OCC_W-1:0]      w_occ_next;
    logic [IDX_W-1:0]      w_ptr_next;

    // A requester whose ack is showing still holds its old word; masking it
    // prevents a second write of the same word.
    assign w_elig   = bus.Req_In & ~r_ack;
    assign w_credit = (r_occ < FULL_CNT);
    assign w_grant  = w_valid & w_credit;
    assign w_rd_acc = bus.Fifo_Rd_En_In & ~bus.Fifo_Empty_In;

    assign w_ptr_next = (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_elig    (w_elig),
        .i_pointer (r_ptr),
        .o_valid   (w_valid),
        .o_winner  (w_winner)
    );

    // Credit uses the pre-update count; a read here frees credit next cycle.
    // A read reported against zero credit is a consumer error and is ignored.
    always_comb begin
        w_occ_next = r_occ;
        if (w_grant && !w_rd_acc) begin
            w_occ_next = r_occ + OCC_W'(1);
        end else if (!w_grant && w_rd_acc && (r_occ != '0)) begin
            w_occ_next = r_occ - OCC_W'(1);
        end
    end

    always_ff @(posedge Clk_In) begin
        if (!Reset_In) begin
            r_ack   <= '0;
            r_wr_en <= 1'b0;
            r_data  <= '0;
            r_occ   <= '0;
            r_ptr   <= '0;
            r_state <= IDLE;
        end else begin
            r_occ <= w_occ_next;
            if (w_grant) begin
                r_wr_en <= 1'b1;
                r_data  <= bus.Req_Data_In[w_winner*DATA_WIDTH +: DATA_WIDTH];
                r_ack   <= NUM_REQ'(1) << w_winner;
                r_ptr   <= w_ptr_next;
            end else begin
                r_wr_en <= 1'b0;
                r_ack   <= '0;
            end
            case (r_state)
                IDLE, STALL: begin
                    if (!w_valid)      r_state <= IDLE;
                    else if (w_credit) r_state <= GRANT;
                    else               r_state <= STALL;
                end
                GRANT: begin
                    if (!w_valid)                    r_state <= IDLE;
                    else if (w_occ_next == FULL_CNT) r_state <= STALL;
                    else                             r_state <= GRANT;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Ack_Out        = r_ack;
    assign bus.Fifo_Wr_En_Out = r_wr_en;
    assign bus.Fifo_Data_Out  = r_data;
    assign bus.Occupancy_Out  = r_occ;
    assign bus.Stall_Out      = (r_state == STALL);

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// tb/tb_fifo_rr_write_arbiter.sv - scoreboard bench for the round-robin FIFO write arbiter
module tb_fifo_rr_write_arbiter;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic Clk_In   = 1'b0;
    logic Reset_In = 1'b0;

    fifo_rr_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .FIFO_DEPTH(8)) bus ();

    fifo_rr_write_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (8)
    ) dut (
        .Clk_In   (Clk_In),
        .Reset_In (Reset_In),
        .bus      (bus)
    );

    always #5 Clk_In = ~Clk_In;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_wr[$];
    logic [7:0] exp_rd[$];

    // Behavioural 8-deep, 8-bit FIFO on the arbiter's write port.
    logic [7:0] f_mem [8];
    int f_wp  = 0;
    int f_rp  = 0;
    int f_cnt = 0;

    assign bus.Fifo_Empty_In = (f_cnt == 0);

    always @(posedge Clk_In) begin
        if (!Reset_In) begin
            f_wp  <= 0;
            f_rp  <= 0;
            f_cnt <= 0;
        end else begin
            automatic bit do_wr = bus.Fifo_Wr_En_Out && (f_cnt < 8);
            automatic bit do_rd = bus.Fifo_Rd_En_In && (f_cnt > 0);
            if (do_wr) begin
                f_mem[f_wp] <= bus.Fifo_Data_Out;
                f_wp        <= (f_wp + 1) % 8;
            end
            if (do_rd) f_rp <= (f_rp + 1) % 8;
            f_cnt <= f_cnt + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every write and every accepted read is matched against the scoreboard.
    always @(negedge Clk_In) begin
        if (Reset_In) begin
            if (bus.Fifo_Wr_En_Out) begin
                check("no_overflow", (f_cnt < 8), 1);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", bus.Fifo_Data_Out, 32'hFFFF_FFFF);
                end else begin
                    automatic exp_t e = exp_wr.pop_front();
                    check("write_data", bus.Fifo_Data_Out, e.data);
                    check("write_ack", bus.Ack_Out, 32'(4'b0001 << e.id));
                end
            end else if (bus.Ack_Out != 4'b0000) begin
                check("ack_without_write", bus.Ack_Out, 0);
            end
            if (bus.Fifo_Rd_En_In && (f_cnt > 0)) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_read", f_mem[f_rp], 32'hFFFF_FFFF);
                end else begin
                    check("read_order", f_mem[f_rp], exp_rd.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk_In);
        #1;
    endtask

    task automatic expect_write(input int id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_wr.push_back(e);
        exp_rd.push_back(data);
    endtask

    localparam int OCC_TRACE [8] = '{4, 4, 3, 3, 2, 2, 1, 1};

    initial begin
        bus.Req_In        = 4'hF;
        bus.Req_Data_In   = 32'h0;
        bus.Fifo_Rd_En_In = 1'b0;

        // 1: reset with all requests asserted
        Reset_In = 1'b0;
        tick();
        tick();
        check("rst_ack", bus.Ack_Out, 0);
        check("rst_wr_en", bus.Fifo_Wr_En_Out, 0);
        check("rst_data", bus.Fifo_Data_Out, 0);
        check("rst_occ", bus.Occupancy_Out, 0);
        check("rst_stall", bus.Stall_Out, 0);
        Reset_In   = 1'b1;
        bus.Req_In = 4'h0;
        tick();

        // 6a: read against an empty FIFO
        bus.Fifo_Rd_En_In = 1'b1;
        tick();
        bus.Fifo_Rd_En_In = 1'b0;
        check("empty_read_occ", bus.Occupancy_Out, 0);

        // 2: single requester, held through its ack cycle
        bus.Req_In             = 4'b0100;
        bus.Req_Data_In[23:16] = 8'hA5;
        expect_write(2, 8'hA5);
        tick();
        check("single_ack", bus.Ack_Out, 4'b0100);
        tick();
        bus.Req_In = 4'h0;
        check("single_no_rewrite", bus.Fifo_Wr_En_Out, 0);
        check("single_occ", bus.Occupancy_Out, 1);
        bus.Fifo_Rd_En_In = 1'b1;
        tick();
        bus.Fifo_Rd_En_In = 1'b0;
        tick();
        check("drain_occ", bus.Occupancy_Out, 0);

        // Reset so the rotation starts at requester 0.
        Reset_In = 1'b0;
        tick();
        Reset_In = 1'b1;

        // 3: all four requesting, no reads -> strict rotation until full
        bus.Req_Data_In = 32'h33_32_31_30;
        bus.Req_In      = 4'hF;
        for (int i = 0; i < 8; i++) expect_write(i % 4, 8'(8'h30 + (i % 4)));
        repeat (12) tick();
        check("full_occ", bus.Occupancy_Out, 8);
        check("full_stall", bus.Stall_Out, 1);
        check("fifo_full", f_cnt, 8);

        // 4: one read returns one credit; next in rotation is requester 0
        bus.Fifo_Rd_En_In = 1'b1;
        tick();
        bus.Fifo_Rd_En_In = 1'b0;
        check("credit_occ_7", bus.Occupancy_Out, 7);
        expect_write(0, 8'h30);
        tick();
        check("credit_write", bus.Fifo_Wr_En_Out, 1);
        check("credit_occ_8", bus.Occupancy_Out, 8);
        repeat (4) tick();

        // 5: drain to 4, then one requester against a read every cycle
        bus.Req_In        = 4'h0;
        bus.Fifo_Rd_En_In = 1'b1;
        repeat (4) tick();
        bus.Req_In = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                bus.Req_Data_In[15:8] = 8'(8'h50 + i / 2);
                expect_write(1, 8'(8'h50 + i / 2));
            end
            check("concurrent_occ", bus.Occupancy_Out, OCC_TRACE[i]);
            tick();
        end
        bus.Req_In        = 4'h0;
        bus.Fifo_Rd_En_In = 1'b0;
        check("concurrent_end_occ", bus.Occupancy_Out, 1);
        tick();
        bus.Fifo_Rd_En_In = 1'b1;
        tick();
        bus.Fifo_Rd_En_In = 1'b0;
        tick();
        check("concurrent_drain_occ", bus.Occupancy_Out, 0);

        // 6b: reset asserted in the cycle a grant would be made
        bus.Req_In            = 4'b0001;
        bus.Req_Data_In[7:0]  = 8'h77;
        Reset_In              = 1'b0;
        tick();
        check("midrst_wr_en", bus.Fifo_Wr_En_Out, 0);
        check("midrst_ack", bus.Ack_Out, 0);
        check("midrst_occ", bus.Occupancy_Out, 0);
        Reset_In   = 1'b1;
        bus.Req_In = 4'h0;
        tick();
        tick();

        // Recovery: a fresh request after reset is served normally.
        bus.Req_In              = 4'b1000;
        bus.Req_Data_In[31:24]  = 8'h9C;
        expect_write(3, 8'h9C);
        tick();
        tick();
        bus.Req_In = 4'h0;
        check("recover_occ", bus.Occupancy_Out, 1);
        bus.Fifo_Rd_En_In = 1'b1;
        tick();
        bus.Fifo_Rd_En_In = 1'b0;
        repeat (3) tick();

        check("pending_writes", exp_wr.size(), 0);
        check("pending_reads", exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
